uart_tx_fifo: RTL

Byte-wide UART transmitter with a small input FIFO, the outbound counterpart of the board's UART receiver. It serialises 8N1 frames (8E1 when parity is compiled in) at a fixed baud derived from the internal oscillator clock. It sits between command/status logic, such as colour-command acknowledgements, and the FPGA's UART TX pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo_if.sv | 10 +
 rtl/uart_tx_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding.
// The receiver imports the same clock/baud defaults so both ends agree on
// the bit period.
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT = 12_000_000;
  localparam int BAUD_DEFAULT     = 115_200;

  // Whole oscillator cycles per serial bit; the fractional part is dropped.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  localparam int CLKS_PER_BIT_DEFAULT = clks_per_bit(CLK_FREQ_DEFAULT, BAUD_DEFAULT);

  // PARITY is only reachable when the parity build option is enabled.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push channel into the UART transmitter: valid/ready handshake.
// The producer owns data/valid, the transmitter owns ready.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Small synchronous circular FIFO with first-word fall-through head.
// Pointers wrap naturally (depth is a power of two); count has one extra bit
// so that full and empty are distinct. Push when full and pop when empty are
// ignored, so a push into a full FIFO is refused even if a pop happens in the
// same cycle.
module uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: 8N1 frames by default, 8E1 when the
// UART_TX_PARITY_EN macro is defined (adds a PARITY state after DATA).
// The line output is a register fed from the current state, so the start bit
// appears two edges after a byte is accepted into an idle transmitter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int BAUD       = BAUD_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          int_clk,
  input  logic          rst,
  uart_tx_fifo_if.slave tx_if,
  output logic          uart_tx,
  output logic          tx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          uart_tx_q, uart_tx_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          bit_done;

  // Ready is decoded from the registered count, i.e. before any same-cycle pop.
  assign tx_if.tx_ready = (fifo_count < DEPTH_CNT);
  assign fifo_push      = tx_if.tx_valid && !fifo_full;
  assign bit_done       = (timer_q == '0);
  assign uart_tx        = uart_tx_q;
  assign tx_busy        = (state_q != IDLE) || !fifo_empty;

  uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (int_clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (tx_if.tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State, bit timer, shifter and line register.
  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      uart_tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      uart_tx_q <= uart_tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Frame sequencing: pop a byte, then START, 8 DATA bits, [PARITY], STOP.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          timer_d  = TIMER_LOAD;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_head;
`endif
        end
      end

      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
          timer_d   = TIMER_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      DATA: begin
        if (bit_done) begin
          timer_d = TIMER_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          timer_d = TIMER_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit when more bytes wait.
          if (!fifo_empty) begin
            state_d  = START;
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            timer_d  = TIMER_LOAD;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_head;
`endif
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Line level for the next cycle, taken from the current state.
  always_comb begin
    uart_tx_d = 1'b1;
    case (state_q)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  uart_tx_d = parity_q;
`endif
      default: uart_tx_d = 1'b1;
    endcase
  end

endmodule
